// File: rtl/shift_seq_unit_if.sv
// Handshake and data bundle between the multicycle control/datapath and the
// iterative shift engine.
interface shift_seq_unit_if #(
  parameter int DATA_W = 32,
  parameter int N_W    = 5
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] data_in;
  logic [N_W-1:0]    n;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;

  modport master (
    output start, op, data_in, n,
    input  data_out, busy, done
  );

  modport slave (
    input  start, op, data_in, n,
    output data_out, busy, done
  );
endinterface

// File: rtl/shift_seq_unit.sv
// Iterative SLL/SRL/SRA/ROR engine: one bit position per clock, with a
// start/busy/done handshake for the multicycle control unit.
module shift_seq_unit #(
  parameter int DATA_W = 32,
  parameter int N_W    = 5
) (
  input logic               clk,
  input logic               reset,
  shift_seq_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t            state;
  logic [N_W-1:0]    count;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] step_val;

  // One-bit step of the working register; unknown encodings fall back to SLL.
  always_comb begin
    step_val = {bus.data_out[DATA_W-2:0], 1'b0};
    case (op_q)
      OP_SLL: step_val = {bus.data_out[DATA_W-2:0], 1'b0};
      OP_SRL: step_val = {1'b0, bus.data_out[DATA_W-1:1]};
      OP_SRA: step_val = {bus.data_out[DATA_W-1], bus.data_out[DATA_W-1:1]};
      OP_ROR: step_val = {bus.data_out[0], bus.data_out[DATA_W-1:1]};
      default: step_val = {bus.data_out[DATA_W-2:0], 1'b0};
    endcase
  end

  // busy/done are registered, so they are set on the edge that enters the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.data_out <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      count        <= '0;
      op_q         <= OP_SLL;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.data_out <= bus.data_in;
            op_q         <= bus.op;
            count        <= bus.n;
            bus.busy     <= 1'b1;
            if (bus.n == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state    <= SHIFT;
              bus.done <= 1'b0;
            end
          end
        end

        SHIFT: begin
          bus.data_out <= step_val;
          count        <= count - 1'b1;
          if (count == N_W'(1)) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: directed vector table, randomized
// operations against an arithmetic reference model, and multi-cycle corners.
module tb_shift_seq_unit;

  localparam int DATA_W = 32;
  localparam int N_W    = 5;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  shift_seq_unit_if #(.DATA_W(DATA_W), .N_W(N_W)) sif ();

  shift_seq_unit #(.DATA_W(DATA_W), .N_W(N_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          n;
    logic [31:0] expected;
  } vec_t;

  // Reference shift computed directly from the operation's arithmetic meaning.
  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] d, int n);
    logic [31:0] r;
    case (op)
      2'b00: r = d << n;
      2'b01: r = d >> n;
      2'b10: r = $unsigned($signed(d) >>> n);
      default: r = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
    endcase
    return r;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(logic s, logic [1:0] op, logic [31:0] d, int n);
    sif.start   = s;
    sif.op      = op;
    sif.data_in = d;
    sif.n       = N_W'(n);
  endtask

  // Called at the negedge after the accept edge; returns cycles until done.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (sif.done !== 1'b1 && cycles <= 64) begin
      checkOutput("busy_during_shift", {31'd0, sif.busy}, 32'd1);
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic runOp(string name, logic [1:0] op, logic [31:0] d, int n, logic [31:0] expected);
    int cycles;
    applyStimulus(1'b1, op, d, n);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 31));
    waitDone(cycles);
    checkOutput({name, "_latency"}, cycles, n);
    checkOutput({name, "_result"}, sif.data_out, expected);
    checkOutput({name, "_busy_at_done"}, {31'd0, sif.busy}, 32'd1);
    @(negedge clk);
    checkOutput({name, "_done_pulse"}, {31'd0, sif.done}, 32'd0);
    checkOutput({name, "_idle_busy"}, {31'd0, sif.busy}, 32'd0);
    checkOutput({name, "_hold"}, sif.data_out, expected);
  endtask

  initial begin
    vec_t vecs[6];
    int   cycles;
    int   pulses;
    logic [1:0]  rop;
    logic [31:0] rdata;
    int          rn;

    vecs[0] = '{2'b00, 32'h0000_0001, 31, 32'h8000_0000};
    vecs[1] = '{2'b10, 32'h8000_0010, 4,  32'hF800_0001};
    vecs[2] = '{2'b01, 32'h8000_0010, 4,  32'h0800_0001};
    vecs[3] = '{2'b11, 32'h0000_0001, 1,  32'h8000_0000};
    vecs[4] = '{2'b11, 32'h0000_0001, 0,  32'h0000_0001};
    vecs[5] = '{2'b01, 32'h0000_FF00, 8,  32'h0000_00FF};

    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, 32'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_data_out", sif.data_out, 32'h0);
    checkOutput("reset_busy", {31'd0, sif.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, sif.done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].n, vecs[i].expected);

    // Result hold after the last table vector (SRL 0xFF00 by 8).
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_data_out", sif.data_out, 32'h0000_00FF);
      checkOutput("hold_busy", {31'd0, sif.busy}, 32'd0);
    end

    // start held high throughout; data_in changes after acceptance.
    applyStimulus(1'b1, 2'b01, 32'hF000_0000, 28);
    @(posedge clk);
    @(negedge clk);
    sif.data_in = 32'hFFFF_FFFF;
    waitDone(cycles);
    checkOutput("held_start_latency", cycles, 28);
    checkOutput("held_start_result", sif.data_out, 32'h0000_000F);
    @(negedge clk);
    checkOutput("held_start_idle_done", {31'd0, sif.done}, 32'd0);
    checkOutput("held_start_idle_busy", {31'd0, sif.busy}, 32'd0);
    checkOutput("held_start_idle_hold", sif.data_out, 32'h0000_000F);
    @(negedge clk);
    checkOutput("second_accept_busy", {31'd0, sif.busy}, 32'd1);
    sif.start = 1'b0;
    waitDone(cycles);
    checkOutput("second_latency", cycles, 28);
    checkOutput("second_result", sif.data_out, 32'h0000_000F);
    @(negedge clk);
    checkOutput("second_done_pulse", {31'd0, sif.done}, 32'd0);

    // Reset at edge 3 of SLL n=10 abandons the shift.
    applyStimulus(1'b1, 2'b00, 32'h1234_5679, 10);
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_data_out", sif.data_out, 32'h0);
    checkOutput("midreset_busy", {31'd0, sif.busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, sif.done}, 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (sif.done === 1'b1 || sif.busy === 1'b1) pulses++;
    end
    checkOutput("midreset_no_activity", pulses, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop   = 2'($urandom_range(0, 3));
      rdata = $urandom;
      rn    = $urandom_range(0, 31);
      runOp($sformatf("rand%0d", i), rop, rdata, rn, model(rop, rdata, rn));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Iterative shift engine that consumes the 5-bit shift amount produced by the shift-amount selector, plus a 32-bit operand.
- Performs SLL/SRL/SRA/ROR one bit position per clock under a start/busy/done handshake.
- Sits in the datapath between the shift-amount/operand muxes and the register-file write-back mux.
- The multicycle control unit starts it and waits for done before advancing.

Parameters:
- DATA_W, 32, operand/result width.
- N_W, 5, shift-amount width (must satisfy 2^N_W >= DATA_W).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a shift; sampled only in IDLE.
- op  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROR (rotate right).
- data_in  input  DATA_W  operand, captured on an accepted start.
- n  input  N_W  shift amount (selector output), captured on an accepted start.
- data_out  output  DATA_W  working/result register.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; the result is valid in this cycle.

Behaviour:
- Reset, when sampled high on a rising edge:
  - state<=IDLE; data_out<=0; busy<=0; done<=0.
  - internal count<=0; op_q<=00.
  - Reset has priority over every other condition, including mid-operation: the shift is abandoned and the partial result discarded.
- States are IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0; data_out holds its last value, i.e. the previous result.
  - On an edge with start=1:
    - data_out<=data_in; op_q<=op; count<=n.
    - Next state is DONE if n==0, else SHIFT.
- SHIFT:
  - busy=1, done=0.
  - Each edge applies one 1-bit step to data_out per op_q:
    - SLL: {d[30:0],0}.
    - SRL: {0,d[31:1]}.
    - SRA: {d[31],d[31:1]}.
    - ROR: {d[0],d[31:1]}.
  - count<=count-1 on the same edge.
  - When count==1 at that edge, next state is DONE; otherwise stay in SHIFT.
- DONE:
  - busy=1, done=1 for exactly one cycle; data_out holds the final result.
  - Next edge returns unconditionally to IDLE.
  - start is ignored in DONE, so back-to-back operations need start in the following IDLE cycle.
- Latency: with the start-accept edge as edge 0, done is high in the cycle after edge n (n=0 gives done after edge 0). Total n+1 cycles from start to done.
- start in SHIFT or DONE is ignored; op, data_in and n may change freely after acceptance without effect.
- Intermediate data_out values during SHIFT are visible but not architecturally valid. Consumers sample only while done=1, or in IDLE afterward.
- Width rules:
  - n is unsigned.
  - n=31 is the maximum and produces exactly 31 steps.
  - No modulo or saturation logic is needed, since N_W bits never exceed DATA_W-1 at the defaults.
- Unknown/X on op after reset is not permitted. The op decode default is SLL.

Test Plan:
- SLL, data_in=0x00000001, n=31 -> busy high 32 cycles, done pulse after edge 31, data_out=0x80000000.
- SRA, data_in=0x80000010, n=4 -> done after edge 4, data_out=0xF8000001. Then SRL with the same inputs -> 0x08000001.
- ROR, data_in=0x00000001, n=1 -> done after edge 1, data_out=0x80000000. With n=0 -> done after edge 0, data_out=0x00000001 unchanged.
- start held high continuously, data_in changed mid-shift to 0xFFFFFFFF (first op SRL 0xF0000000, n=28):
  - -> result 0x0000000F.
  - Second operation is accepted only in the IDLE cycle after the done pulse.
  - Exactly one done pulse per operation.
- reset asserted at edge 3 of an SLL n=10 -> next cycle state IDLE, data_out=0, busy=0, done=0. No done pulse follows.
- Result hold: after done for SRL 0x0000FF00 n=8 (=0x000000FF), keep start=0 for 5 cycles -> data_out stays 0x000000FF, busy=0.
